// File: rtl/bus_port_pkg.sv
// Shared constants for the bus port: destination ID field, broadcast ID and error flag positions.
package bus_port_pkg;

  localparam int unsigned ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Bit positions inside the sticky err vector
  typedef enum logic [1:0] {
    ERR_POP_EMPTY = 2'd0,
    ERR_TX_OVF    = 2'd1,
    ERR_RX_OVF    = 2'd2
  } err_idx_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count; a read and a write in the
// same cycle both succeed even when full.
module sync_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [width-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [width-1:0]             rd_data,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(depth);
  localparam int unsigned CNT_W = $clog2(depth+1);

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(depth));
  assign rd_data = mem[rd_ptr];
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is legal when the head retires on the same edge
  assign do_wr   = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_wr && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/bus_port_fifo.sv
// Bus device port: host-to-bus TX FIFO and bus-to-host RX FIFO with destination ID filtering,
// misroute pulse and sticky error flags.
module bus_port_fifo
  import bus_port_pkg::*;
#(
  parameter int unsigned     bits      = 1,
  parameter int unsigned     drvrs     = 4,
  parameter int unsigned     pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = BROADCAST_ID,
  parameter int unsigned     id        = 0,
  parameter int unsigned     depth     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [pckg_sz-1:0]          wr_data,
  output logic                        tx_full,
  output logic                        pndng,
  output logic [pckg_sz-1:0]          D_pop,
  input  logic                        pop,
  input  logic                        push,
  input  logic [pckg_sz-1:0]          D_push,
  input  logic                        rd_en,
  output logic [pckg_sz-1:0]          rd_data,
  output logic                        rx_empty,
  output logic [$clog2(depth+1)-1:0]  tx_count,
  output logic [$clog2(depth+1)-1:0]  rx_count,
  output logic                        misroute,
  output logic [2:0]                  err
);

  if (bits != 1 || id >= drvrs || depth < 2 || (depth & (depth - 1)) != 0) begin : g_bad_params
    $error("bus_port_fifo: unsupported parameter combination");
  end

  logic              tx_empty;
  logic              rx_full;
  logic              id_match;
  logic              rx_wr;
  logic [2:0]        err_set;
  logic [ID_W-1:0]   dest;

  assign pndng    = !tx_empty;
  assign dest     = D_push[pckg_sz-1 -: ID_W];
  assign id_match = (dest == ID_W'(id)) || (dest == broadcast);
  assign rx_wr    = push && id_match;

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (D_pop),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (rx_wr),
    .wr_data (D_push),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  // New error events this cycle; a same-cycle retire rescues a write into a full FIFO
  always_comb begin
    err_set                = '0;
    err_set[ERR_POP_EMPTY] = pop && tx_empty;
    err_set[ERR_TX_OVF]    = wr_en && tx_full && !pop;
    err_set[ERR_RX_OVF]    = rx_wr && rx_full && !rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err      <= '0;
      misroute <= 1'b0;
    end else begin
      err      <= err | err_set;
      misroute <= push && !id_match;
    end
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo (id=2, depth=8, 16-bit packets) with immediate-assertion checks.
module tb_bus_port_fifo;

  localparam int unsigned PW  = 16;
  localparam int unsigned DEP = 8;
  localparam int unsigned CW  = $clog2(DEP+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [PW-1:0] wr_data;
  logic          tx_full;
  logic          pndng;
  logic [PW-1:0] D_pop;
  logic          pop;
  logic          push;
  logic [PW-1:0] D_push;
  logic          rd_en;
  logic [PW-1:0] rd_data;
  logic          rx_empty;
  logic [CW-1:0] tx_count;
  logic [CW-1:0] rx_count;
  logic          misroute;
  logic [2:0]    err;

  int vectors = 0;
  int errors  = 0;

  bus_port_fifo #(
    .bits(1), .drvrs(4), .pckg_sz(PW), .broadcast(8'hFF), .id(2), .depth(DEP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_full  (tx_full),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rx_empty (rx_empty),
    .tx_count (tx_count),
    .rx_count (rx_count),
    .misroute (misroute),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; pop = 1'b0;
    push = 1'b0; D_push = '0; rd_en = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_pndng",    32'(pndng),    32'd0);
    check("rst_tx_full",  32'(tx_full),  32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_misroute", 32'(misroute), 32'd0);

    // Single write then pop
    wr_en = 1'b1; wr_data = 16'h01AB;
    tick();
    wr_en = 1'b0;
    check("wr1_pndng", 32'(pndng), 32'd1);
    check("wr1_D_pop", 32'(D_pop), 32'h01AB);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("pop1_pndng", 32'(pndng),    32'd0);
    check("pop1_count", 32'(tx_count), 32'd0);

    // Fill to 8, 9th dropped
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = PW'(16'h1000 + i);
      tick();
    end
    check("fill_full",  32'(tx_full),  32'd1);
    check("fill_count", 32'(tx_count), 32'd8);
    wr_data = 16'h10FF;
    tick();
    wr_en = 1'b0;
    check("ovf_count", 32'(tx_count), 32'd8);
    check("ovf_err",   32'(err),      32'b010);
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(D_pop), 32'h1000 + 32'(i));
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    check("drain_pndng", 32'(pndng), 32'd0);

    // Full TX with simultaneous write and pop
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = PW'(16'h2000 + i);
      tick();
    end
    wr_data = 16'hBEEF; pop = 1'b1;
    tick();
    wr_en = 1'b0; pop = 1'b0;
    check("wrpop_count", 32'(tx_count), 32'd8);
    check("wrpop_err",   32'(err),      32'b010);
    for (int i = 1; i < 8; i++) begin
      check("wrpop_order", 32'(D_pop), 32'h2000 + 32'(i));
      pop = 1'b1;
      tick();
    end
    check("wrpop_last", 32'(D_pop), 32'hBEEF);
    tick();
    pop = 1'b0;
    check("wrpop_empty", 32'(pndng), 32'd0);

    // Pop while empty
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("popempty_err",   32'(err),      32'b011);
    check("popempty_count", 32'(tx_count), 32'd0);

    // RX address filtering
    push = 1'b1; D_push = 16'h02CD;
    tick();
    check("rx_own_data",  32'(rd_data),  32'h02CD);
    check("rx_own_count", 32'(rx_count), 32'd1);
    check("rx_own_mis",   32'(misroute), 32'd0);
    D_push = 16'hFF11;
    tick();
    check("rx_bc_count", 32'(rx_count), 32'd2);
    D_push = 16'h0333;
    tick();
    push = 1'b0;
    check("rx_mis_pulse", 32'(misroute), 32'd1);
    check("rx_mis_count", 32'(rx_count), 32'd2);
    tick();
    check("rx_mis_end", 32'(misroute), 32'd0);
    rd_en = 1'b1;
    tick();
    check("rx_rd1_data", 32'(rd_data), 32'hFF11);
    tick();
    check("rx_rd2_empty", 32'(rx_empty), 32'd1);
    tick();
    rd_en = 1'b0;
    check("rx_rdempty_err",   32'(err),      32'b011);
    check("rx_rdempty_count", 32'(rx_count), 32'd0);

    // RX overflow, then push with read while full
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      D_push = PW'(16'h0200 + i);
      tick();
    end
    D_push = 16'h02EE;
    tick();
    check("rxovf_err",   32'(err),      32'b111);
    check("rxovf_count", 32'(rx_count), 32'd8);
    D_push = 16'h02DD; rd_en = 1'b1;
    tick();
    push = 1'b0; rd_en = 1'b0;
    check("rxfull_rw_count", 32'(rx_count), 32'd8);
    check("rxfull_rw_head",  32'(rd_data),  32'h0201);

    // Reset mid-stream with 4 TX entries queued, other controls active
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = PW'(16'h3000 + i);
      tick();
    end
    wr_en = 1'b0;
    check("pre_rst_count", 32'(tx_count), 32'd4);
    reset = 1'b1; wr_en = 1'b1; pop = 1'b1; push = 1'b1; D_push = 16'h0244; rd_en = 1'b1;
    tick();
    reset = 1'b0; wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
    check("mid_rst_count",    32'(tx_count), 32'd0);
    check("mid_rst_pndng",    32'(pndng),    32'd0);
    check("mid_rst_rx_empty", 32'(rx_empty), 32'd1);
    check("mid_rst_err",      32'(err),      32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
